// File: rtl/hazard_pkg.sv
// Shared types and constants for the hazard controller: forward encodings,
// memory-wait FSM states and the register-index match helper.
package hazard_pkg;

    localparam int unsigned REG_W = 5;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef enum logic [1:0] {RUN, WAIT, ERR} memState_e;

    // $0 is hardwired to zero, so it never creates a dependency.
    function automatic logic regMatch(input logic [REG_W-1:0] a, input logic [REG_W-1:0] b);
        return (a != '0) && (a == b);
    endfunction

endpackage

// File: rtl/hazard_unit_if.sv
// Datapath <-> hazard unit bundle: decode-stage fields and the memory handshake
// in, stall/flush/forward controls and the watchdog flag out.
interface hazard_unit_if;
    import hazard_pkg::*;

    logic [REG_W-1:0] rsD;
    logic [REG_W-1:0] rtD;
    logic [REG_W-1:0] rdD;
    logic             regdstD;
    logic             regwriteD;
    logic             memtoregD;
    logic             memwriteD;
    logic             branchD;
    logic             dmem_ready;

    logic             stallF;
    logic             stallD;
    logic             stallE;
    logic             stallM;
    logic             flushE;
    logic             flushW;
    logic             forwardAD;
    logic             forwardBD;
    logic [1:0]       forwardAE;
    logic [1:0]       forwardBE;
    logic             mem_timeout;

    modport master (
        output rsD, rtD, rdD, regdstD, regwriteD, memtoregD, memwriteD, branchD, dmem_ready,
        input  stallF, stallD, stallE, stallM, flushE, flushW,
        input  forwardAD, forwardBD, forwardAE, forwardBE, mem_timeout
    );

    modport slave (
        input  rsD, rtD, rdD, regdstD, regwriteD, memtoregD, memwriteD, branchD, dmem_ready,
        output stallF, stallD, stallE, stallM, flushE, flushW,
        output forwardAD, forwardBD, forwardAE, forwardBE, mem_timeout
    );

endinterface

// File: rtl/hazard_fwd_sel.sv
// ALU operand forward selector for one E-stage source register; M beats W
// because it holds the younger result.
module hazard_fwd_sel
    import hazard_pkg::*;
(
    input  logic [REG_W-1:0] srcE,
    input  logic [REG_W-1:0] writeregM,
    input  logic             regwriteM,
    input  logic [REG_W-1:0] writeregW,
    input  logic             regwriteW,
    output logic [1:0]       forward
);

    always_comb begin
        forward = FWD_RF;
        if (regwriteM && regMatch(srcE, writeregM)) begin
            forward = FWD_MEM;
        end else if (regwriteW && regMatch(srcE, writeregW)) begin
            forward = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_unit.sv
// Hazard controller for the 5-stage MIPS pipe: forwarding, load-use/branch stalls
// and a dmem wait-state freeze with a sticky watchdog. Define HAZARD_STATS_EN for stall_cycles.
module hazard_unit
    import hazard_pkg::*;
#(
    parameter int unsigned WAIT_TIMEOUT = 64,
    parameter int unsigned CNT_W        = 8
) (
    input  logic        clk,
    input  logic        reset,
    hazard_unit_if.slave hz
`ifdef HAZARD_STATS_EN
    ,
    output logic [31:0] stall_cycles
`endif
);

    logic [REG_W-1:0] writeregD;
    logic [REG_W-1:0] rsE, rtE, writeregE, writeregM, writeregW;
    logic             regwriteE, memtoregE, memwriteE;
    logic             regwriteM, memtoregM, memwriteM;
    logic             regwriteW;

    memState_e        state;
    logic [CNT_W-1:0] waitCnt;
    logic             memTimeout;

    logic lwstall, branchstall, hazStall, memMiss, freeze;
    logic stallF, stallD, stallE, stallM, flushE, flushW;

    assign writeregD = hz.regdstD ? hz.rdD : hz.rtD;

    assign lwstall = memtoregE && (regMatch(hz.rsD, rtE) || regMatch(hz.rtD, rtE));
    assign branchstall = hz.branchD &&
        ((regwriteE && (regMatch(hz.rsD, writeregE) || regMatch(hz.rtD, writeregE))) ||
         (memtoregM && (regMatch(hz.rsD, writeregM) || regMatch(hz.rtD, writeregM))));
    assign hazStall = lwstall || branchstall;

    assign memMiss = (memtoregM || memwriteM) && !hz.dmem_ready;
    assign freeze  = (state == ERR) || memMiss;

    // A memory freeze holds E and M in place and drains W; D-stage hazards wait.
    always_comb begin
        stallF = 1'b0;
        stallD = 1'b0;
        stallE = 1'b0;
        stallM = 1'b0;
        flushE = 1'b0;
        flushW = 1'b0;
        if (freeze) begin
            stallF = 1'b1;
            stallD = 1'b1;
            stallE = 1'b1;
            stallM = 1'b1;
            flushW = 1'b1;
        end else begin
            stallF = hazStall;
            stallD = hazStall;
            flushE = hazStall;
        end
    end

    assign hz.stallF      = stallF;
    assign hz.stallD      = stallD;
    assign hz.stallE      = stallE;
    assign hz.stallM      = stallM;
    assign hz.flushE      = flushE;
    assign hz.flushW      = flushW;
    assign hz.mem_timeout = memTimeout;
    assign hz.forwardAD   = regwriteM && regMatch(hz.rsD, writeregM);
    assign hz.forwardBD   = regwriteM && regMatch(hz.rtD, writeregM);

    hazard_fwd_sel u_fwdA (
        .srcE      (rsE),
        .writeregM (writeregM),
        .regwriteM (regwriteM),
        .writeregW (writeregW),
        .regwriteW (regwriteW),
        .forward   (hz.forwardAE)
    );

    hazard_fwd_sel u_fwdB (
        .srcE      (rtE),
        .writeregM (writeregM),
        .regwriteM (regwriteM),
        .writeregW (writeregW),
        .regwriteW (regwriteW),
        .forward   (hz.forwardBE)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            rsE <= '0; rtE <= '0; writeregE <= '0;
            regwriteE <= 1'b0; memtoregE <= 1'b0; memwriteE <= 1'b0;
            writeregM <= '0; regwriteM <= 1'b0; memtoregM <= 1'b0; memwriteM <= 1'b0;
            writeregW <= '0; regwriteW <= 1'b0;
        end else begin
            if (!stallE) begin
                rsE       <= flushE ? '0   : hz.rsD;
                rtE       <= flushE ? '0   : hz.rtD;
                writeregE <= flushE ? '0   : writeregD;
                regwriteE <= flushE ? 1'b0 : hz.regwriteD;
                memtoregE <= flushE ? 1'b0 : hz.memtoregD;
                memwriteE <= flushE ? 1'b0 : hz.memwriteD;
            end
            if (!stallM) begin
                writeregM <= writeregE;
                regwriteM <= regwriteE;
                memtoregM <= memtoregE;
                memwriteM <= memwriteE;
            end
            writeregW <= flushW ? '0   : writeregM;
            regwriteW <= flushW ? 1'b0 : regwriteM;
        end
    end

    // Wait counter includes the RUN->WAIT miss cycle, so ERR follows WAIT_TIMEOUT misses.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= RUN;
            waitCnt    <= '0;
            memTimeout <= 1'b0;
        end else begin
            unique case (state)
                RUN: begin
                    waitCnt <= '0;
                    if (memMiss) begin
                        state   <= WAIT;
                        waitCnt <= CNT_W'(1);
                    end
                end
                WAIT: begin
                    if (hz.dmem_ready) begin
                        state   <= RUN;
                        waitCnt <= '0;
                    end else begin
                        waitCnt <= waitCnt + CNT_W'(1);
                        if (waitCnt >= CNT_W'(WAIT_TIMEOUT - 1)) begin
                            state      <= ERR;
                            memTimeout <= 1'b1;
                        end
                    end
                end
                ERR: state <= ERR;
                default: state <= RUN;
            endcase
        end
    end

`ifdef HAZARD_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles <= '0;
        end else if (stallF && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: directed scenarios plus a random program
// compared against an instruction-level pipeline model.
module tb_hazard_unit;

    localparam int unsigned WAIT_TIMEOUT = 64;

    typedef struct {
        logic [4:0] rs, rt, rd, dst;
        logic       regdst, wr, ld, st, br;
    } instr_t;

    typedef struct packed {
        logic       sF, sD, sE, sM, fE, fW, fAD, fBD;
        logic [1:0] fAE, fBE;
        logic       to;
    } out_t;

    logic clk = 1'b0;
    logic reset;
    hazard_unit_if hz();
`ifdef HAZARD_STATS_EN
    logic [31:0] stallCycles;
`endif

    hazard_unit #(.WAIT_TIMEOUT(WAIT_TIMEOUT), .CNT_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hz)
`ifdef HAZARD_STATS_EN
        ,
        .stall_cycles (stallCycles)
`endif
    );

    always #5 clk = ~clk;

    int     tests = 0;
    int     fails = 0;
    instr_t prog[$];
    int     pc;
    instr_t mE, mM, mW;
    int     missRun;
    bit     err;
    logic   rdyNow;
    int     statCnt;

    function automatic instr_t nop();
        instr_t i = '{default: '0};
        return i;
    endfunction

    function automatic instr_t rtype(int rd, int rs, int rt);
        instr_t i = nop();
        i.rd = 5'(rd); i.rs = 5'(rs); i.rt = 5'(rt); i.dst = 5'(rd);
        i.regdst = 1'b1; i.wr = 1'b1;
        return i;
    endfunction

    function automatic instr_t lw(int rt, int rs);
        instr_t i = nop();
        i.rs = 5'(rs); i.rt = 5'(rt); i.dst = 5'(rt); i.wr = 1'b1; i.ld = 1'b1;
        return i;
    endfunction

    function automatic instr_t sw(int rt, int rs);
        instr_t i = nop();
        i.rs = 5'(rs); i.rt = 5'(rt); i.dst = 5'(rt); i.st = 1'b1;
        return i;
    endfunction

    function automatic instr_t beq(int rs, int rt);
        instr_t i = nop();
        i.rs = 5'(rs); i.rt = 5'(rt); i.dst = 5'(rt); i.br = 1'b1;
        return i;
    endfunction

    function automatic instr_t curD();
        if (pc < prog.size()) return prog[pc];
        return nop();
    endfunction

    function automatic bit match(logic [4:0] a, logic [4:0] b);
        return (a != 5'd0) && (a == b);
    endfunction

    function automatic logic [1:0] selExp(logic [4:0] src);
        if (mM.wr && match(src, mM.dst)) return 2'b10;
        if (mW.wr && match(src, mW.dst)) return 2'b01;
        return 2'b00;
    endfunction

    function automatic bit hazExp(instr_t d);
        bit ls, bs;
        ls = mE.ld && (match(d.rs, mE.rt) || match(d.rt, mE.rt));
        bs = d.br && ((mE.wr && (match(d.rs, mE.dst) || match(d.rt, mE.dst))) ||
                      (mM.ld && (match(d.rs, mM.dst) || match(d.rt, mM.dst))));
        return ls || bs;
    endfunction

    function automatic bit frzExp();
        return err || ((mM.ld || mM.st) && !rdyNow);
    endfunction

    function automatic out_t expOut();
        out_t   e;
        instr_t d = curD();
        bit     f = frzExp();
        bit     h = hazExp(d);
        e.sF = f || h; e.sD = f || h; e.sE = f; e.sM = f; e.fW = f;
        e.fE = !f && h;
        e.fAD = mM.wr && match(d.rs, mM.dst);
        e.fBD = mM.wr && match(d.rt, mM.dst);
        e.fAE = selExp(mE.rs);
        e.fBE = selExp(mE.rt);
        e.to  = err;
        return e;
    endfunction

    function automatic out_t obsOut();
        out_t o;
        o.sF = hz.stallF; o.sD = hz.stallD; o.sE = hz.stallE; o.sM = hz.stallM;
        o.fE = hz.flushE; o.fW = hz.flushW; o.fAD = hz.forwardAD; o.fBD = hz.forwardBD;
        o.fAE = hz.forwardAE; o.fBE = hz.forwardBE; o.to = hz.mem_timeout;
        return o;
    endfunction

    // Called just after a posedge: apply the D-stage instruction, then settle to negedge.
    task automatic present(input logic rdy);
        instr_t d = curD();
        hz.rsD = d.rs; hz.rtD = d.rt; hz.rdD = d.rd; hz.regdstD = d.regdst;
        hz.regwriteD = d.wr; hz.memtoregD = d.ld; hz.memwriteD = d.st; hz.branchD = d.br;
        hz.dmem_ready = rdy;
        rdyNow = rdy;
        @(negedge clk);
    endtask

    task automatic tick();
        instr_t d = curD();
        bit h = hazExp(d);
        bit f = frzExp();
        bit miss = (mM.ld || mM.st) && !rdyNow;
        if (f || h) statCnt++;
        @(posedge clk);
        if (!err) begin
            if (miss) begin
                missRun++;
                if (missRun >= WAIT_TIMEOUT) err = 1'b1;
            end else begin
                missRun = 0;
            end
        end
        if (f) begin
            mW = nop();
        end else begin
            mW = mM;
            mM = mE;
            if (h) begin
                mE = nop();
            end else begin
                mE = d;
                pc++;
            end
        end
        #1;
    endtask

    task automatic skip(input int n, input logic rdy);
        repeat (n) begin
            present(rdy);
            tick();
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        prog.delete();
        pc = 0;
        present(1'b1);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        mE = nop(); mM = nop(); mW = nop();
        missRun = 0; err = 1'b0; statCnt = 0;
    endtask

    task automatic test_reset();
        out_t o;
        reset = 1'b1;
        hz.rsD = 5'd3; hz.rtD = 5'd3; hz.rdD = 5'd7; hz.regdstD = 1'b1;
        hz.regwriteD = 1'b1; hz.memtoregD = 1'b1; hz.memwriteD = 1'b0; hz.branchD = 1'b1;
        hz.dmem_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        o = obsOut();
        tests++;
        if (o !== '0) begin
            fails++; $display("FAIL reset_outputs: got %h expected %h", o, 13'h0);
        end
        tests++;
        if (hz.mem_timeout !== 1'b0) begin
            fails++; $display("FAIL reset_timeout: got %b expected 0", hz.mem_timeout);
        end
        do_reset();
    endtask

    task automatic test_alu_forward();
        do_reset();
        prog = '{rtype(3, 1, 2), rtype(4, 3, 3)};
        skip(2, 1'b1);
        present(1'b1);
        tests++;
        if ({hz.forwardAE, hz.forwardBE, hz.stallF} !== 5'b10100) begin
            fails++; $display("FAIL fwd_mem: got %b expected 10100",
                              {hz.forwardAE, hz.forwardBE, hz.stallF});
        end
        tick();
        do_reset();
        prog = '{rtype(3, 1, 2), nop(), rtype(4, 3, 5)};
        skip(3, 1'b1);
        present(1'b1);
        tests++;
        if ({hz.forwardAE, hz.forwardBE, hz.stallF} !== 5'b01000) begin
            fails++; $display("FAIL fwd_wb: got %b expected 01000",
                              {hz.forwardAE, hz.forwardBE, hz.stallF});
        end
        tick();
    endtask

    task automatic test_load_use();
        do_reset();
        prog = '{lw(3, 1), rtype(4, 3, 2)};
        skip(1, 1'b1);
        present(1'b1);
        tests++;
        if ({hz.stallF, hz.stallD, hz.flushE, hz.stallE} !== 4'b1110) begin
            fails++; $display("FAIL lw_stall: got %b expected 1110",
                              {hz.stallF, hz.stallD, hz.flushE, hz.stallE});
        end
        tick();
        present(1'b1);
        tests++;
        if ({hz.stallF, hz.flushE, hz.stallM} !== 3'b000) begin
            fails++; $display("FAIL lw_release: got %b expected 000",
                              {hz.stallF, hz.flushE, hz.stallM});
        end
        tick();
        present(1'b1);
        tests++;
        if ({hz.forwardAE, hz.stallF} !== 3'b010) begin
            fails++; $display("FAIL lw_fwd_wb: got %b expected 010", {hz.forwardAE, hz.stallF});
        end
        tick();
    endtask

    task automatic test_branch();
        do_reset();
        prog = '{rtype(3, 1, 2), beq(3, 0)};
        skip(1, 1'b1);
        present(1'b1);
        tests++;
        if ({hz.stallF, hz.flushE, hz.forwardAD} !== 3'b110) begin
            fails++; $display("FAIL br_stall: got %b expected 110",
                              {hz.stallF, hz.flushE, hz.forwardAD});
        end
        tick();
        present(1'b1);
        tests++;
        if ({hz.stallF, hz.forwardAD, hz.forwardBD} !== 3'b010) begin
            fails++; $display("FAIL br_fwd: got %b expected 010",
                              {hz.stallF, hz.forwardAD, hz.forwardBD});
        end
        tick();
    endtask

    task automatic test_zero_reg();
        do_reset();
        prog = '{rtype(0, 1, 2), rtype(4, 0, 0)};
        skip(2, 1'b1);
        present(1'b1);
        tests++;
        if ({hz.forwardAE, hz.forwardBE, hz.stallF} !== 5'b00000) begin
            fails++; $display("FAIL zero_fwd: got %b expected 00000",
                              {hz.forwardAE, hz.forwardBE, hz.stallF});
        end
        tick();
        do_reset();
        prog = '{lw(0, 1), beq(0, 0)};
        skip(1, 1'b1);
        present(1'b1);
        tests++;
        if ({hz.stallF, hz.flushE} !== 2'b00) begin
            fails++; $display("FAIL zero_stall: got %b expected 00", {hz.stallF, hz.flushE});
        end
        tick();
        present(1'b1);
        tests++;
        if ({hz.stallF, hz.forwardAD, hz.forwardBD} !== 3'b000) begin
            fails++; $display("FAIL zero_brfwd: got %b expected 000",
                              {hz.stallF, hz.forwardAD, hz.forwardBD});
        end
        tick();
    endtask

    task automatic test_mem_wait();
        logic [5:0] v;
        // Ready on the first M cycle: no freeze.
        do_reset();
        prog = '{lw(3, 1)};
        skip(2, 1'b1);
        present(1'b1);
        v = {hz.stallF, hz.stallD, hz.stallE, hz.stallM, hz.flushE, hz.flushW};
        tests++;
        if (v !== 6'b000000) begin
            fails++; $display("FAIL mem_hit: got %b expected 000000", v);
        end
        tick();
        do_reset();
        prog = '{sw(5, 1)};
        skip(2, 1'b1);
        for (int i = 0; i < 3; i++) begin
            present(1'b0);
            v = {hz.stallF, hz.stallD, hz.stallE, hz.stallM, hz.flushE, hz.flushW};
            tests++;
            if (v !== 6'b111101) begin
                fails++; $display("FAIL mem_wait_%0d: got %b expected 111101", i, v);
            end
            tick();
        end
        present(1'b1);
        v = {hz.stallF, hz.stallD, hz.stallE, hz.stallM, hz.flushE, hz.flushW};
        tests++;
        if (v !== 6'b000000) begin
            fails++; $display("FAIL mem_resume: got %b expected 000000", v);
        end
        tick();
        // Freeze overrides a simultaneous load-use hazard.
        do_reset();
        prog = '{lw(3, 1), lw(6, 2), rtype(4, 6, 0)};
        skip(2, 1'b1);
        present(1'b0);
        v = {hz.stallF, hz.stallD, hz.stallE, hz.stallM, hz.flushE, hz.flushW};
        tests++;
        if (v !== 6'b111101) begin
            fails++; $display("FAIL mem_over_lw: got %b expected 111101", v);
        end
        tick();
    endtask

    task automatic test_timeout();
        do_reset();
        prog = '{lw(3, 1)};
        skip(2, 1'b1);
        for (int i = 0; i < int'(WAIT_TIMEOUT); i++) begin
            present(1'b0);
            if (i == int'(WAIT_TIMEOUT) - 1) begin
                tests++;
                if (hz.mem_timeout !== 1'b0) begin
                    fails++; $display("FAIL timeout_early: got %b expected 0", hz.mem_timeout);
                end
            end
            tick();
        end
        present(1'b1);
        tests++;
        if ({hz.mem_timeout, hz.stallF, hz.stallM, hz.flushW} !== 4'b1111) begin
            fails++; $display("FAIL timeout_err: got %b expected 1111",
                              {hz.mem_timeout, hz.stallF, hz.stallM, hz.flushW});
        end
        tick();
        do_reset();
        present(1'b1);
        tests++;
        if (obsOut() !== '0) begin
            fails++; $display("FAIL timeout_clear: got %h expected %h", obsOut(), 13'h0);
        end
        tick();
        // Reset in the middle of a wait returns to RUN with a fresh counter.
        prog = '{sw(5, 1)};
        pc = 0;
        skip(2, 1'b1);
        skip(5, 1'b0);
        do_reset();
        present(1'b1);
        tests++;
        if (obsOut() !== '0) begin
            fails++; $display("FAIL midwait_reset: got %h expected %h", obsOut(), 13'h0);
        end
        tick();
    endtask

    task automatic test_random();
        out_t e, o;
        int   k;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            k = int'($urandom_range(0, 4));
            case (k)
                0: prog.push_back(rtype($urandom_range(0, 7), $urandom_range(0, 7),
                                        $urandom_range(0, 7)));
                1: prog.push_back(lw($urandom_range(0, 7), $urandom_range(0, 7)));
                2: prog.push_back(sw($urandom_range(0, 7), $urandom_range(0, 7)));
                3: prog.push_back(beq($urandom_range(0, 7), $urandom_range(0, 7)));
                default: prog.push_back(nop());
            endcase
        end
        for (int c = 0; c < 600; c++) begin
            present($urandom_range(0, 3) != 0);
            e = expOut();
            o = obsOut();
            tests++;
            if (o !== e) begin
                fails++; $display("FAIL random_c%0d: got %h expected %h", c, o, e);
            end
            tick();
        end
`ifdef HAZARD_STATS_EN
        tests++;
        if (stallCycles !== 32'(statCnt)) begin
            fails++; $display("FAIL stall_cycles: got %0d expected %0d", stallCycles, statCnt);
        end
`endif
    endtask

    initial begin
        reset = 1'b1;
        pc = 0;
        test_reset();
        test_alu_forward();
        test_load_use();
        test_branch();
        test_zero_reg();
        test_mem_wait();
        test_timeout();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
